// File: rtl/xy_gfx_pkg.sv
// Shared helpers for the XY-sample to gfx-beat adapter.
// Width-generic colour expansion; callers pass their own channel widths.
package xy_gfx_pkg;

    localparam int unsigned MAX_CW = 32;

    // Output bit (cw-1-i) takes input bit (in_w-1-(i mod in_w)): truncates to MSBs
    // when the input is wide and replicates MSB-first when it is narrow.
    function automatic logic [MAX_CW-1:0] color_expand(
        input logic [MAX_CW-1:0] c,
        input int unsigned       in_w,
        input int unsigned       cw
    );
        logic [MAX_CW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_CW; i++) begin
            if (i < cw && in_w != 0) begin
                r[cw-1-i] = c[in_w-1-(i % in_w)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xy_gfx_ring.sv
// DEPTH-entry ring buffer; a push into a full buffer with no pop evicts the oldest entry.
module xy_gfx_ring
    import xy_gfx_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_evict
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_diff;
    logic          w_full;
    logic          w_pop;
    logic          w_rd_adv;

    always_comb begin
        w_diff   = r_wr_ptr - r_rd_ptr;
        w_full   = (w_diff == PW'(DEPTH));
        o_empty  = (w_diff == '0);
        w_pop    = i_pop && !o_empty;
        o_evict  = i_push && w_full && !w_pop;
        w_rd_adv = w_pop || o_evict;
        o_level  = LW'(w_diff);
        o_data   = r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_adv) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointer reset alone empties the buffer.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/xy_gfx_fifo.sv
// XY beam samples -> gfx pixel beats: capture, blank/dedup filter, drop-oldest buffer,
// valid/ready output register, saturating drop/skip counters.
module xy_gfx_fifo
    import xy_gfx_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 10,
    parameter int unsigned H_WIDTH        = 12,
    parameter int unsigned V_WIDTH        = 12,
    parameter int unsigned PIXEL_WIDTH    = 12,
    parameter int unsigned COLOR_IN_WIDTH = 1,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_WIDTH-1:0]        s_x,
    input  logic [IN_WIDTH-1:0]        s_y,
    input  logic [COLOR_IN_WIDTH-1:0]  s_red,
    input  logic [COLOR_IN_WIDTH-1:0]  s_grn,
    input  logic [COLOR_IN_WIDTH-1:0]  s_blu,
    input  logic                       cfg_dedup,
    input  logic                       cfg_skip_blank,
    output logic                       m_gfx_valid,
    output logic [H_WIDTH-1:0]         m_gfx_x,
    output logic [V_WIDTH-1:0]         m_gfx_y,
    output logic [PIXEL_WIDTH-1:0]     m_gfx_pixel,
    input  logic                       m_gfx_ready,
    output logic [CNT_WIDTH-1:0]       drop_cnt,
    output logic [CNT_WIDTH-1:0]       skip_cnt,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
    localparam int unsigned CW = PIXEL_WIDTH / 3;
    localparam int unsigned BW = H_WIDTH + V_WIDTH + PIXEL_WIDTH;

    typedef struct packed {
        logic [H_WIDTH-1:0]     x;
        logic [V_WIDTH-1:0]     y;
        logic [PIXEL_WIDTH-1:0] pixel;
    } gfx_beat_t;

    gfx_beat_t             w_beat_in;
    logic [MAX_CW-1:0]     w_r_exp, w_g_exp, w_b_exp;
    logic                  r_s0_valid;
    gfx_beat_t             r_s0_beat;
    gfx_beat_t             r_last;
    logic                  r_last_ok;
    logic                  w_skip_blank, w_dup, w_push, w_pop;
    logic [BW-1:0]         w_head;
    logic                  w_empty, w_evict;
    logic                  r_out_valid;
    gfx_beat_t             r_out_beat;
    logic [CNT_WIDTH-1:0]  r_drop_cnt, r_skip_cnt;

    always_comb begin
        w_r_exp = color_expand(MAX_CW'(s_red), COLOR_IN_WIDTH, CW);
        w_g_exp = color_expand(MAX_CW'(s_grn), COLOR_IN_WIDTH, CW);
        w_b_exp = color_expand(MAX_CW'(s_blu), COLOR_IN_WIDTH, CW);
        w_beat_in       = '0;
        w_beat_in.x     = H_WIDTH'(s_x);
        w_beat_in.y     = V_WIDTH'(s_y);
        w_beat_in.pixel = PIXEL_WIDTH'({w_r_exp[CW-1:0], w_g_exp[CW-1:0], w_b_exp[CW-1:0]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_beat  <= '0;
        end else begin
            r_s0_valid <= s_valid;
            if (s_valid) r_s0_beat <= w_beat_in;
        end
    end

    always_comb begin
        w_skip_blank = r_s0_valid && cfg_skip_blank && (r_s0_beat.pixel == '0);
        w_dup        = r_s0_valid && !w_skip_blank && cfg_dedup && r_last_ok && (r_s0_beat == r_last);
        w_push       = r_s0_valid && !w_skip_blank && !w_dup;
        w_pop        = !w_empty && (!r_out_valid || m_gfx_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last    <= '0;
            r_last_ok <= 1'b0;
        end else if (w_skip_blank) begin
            r_last_ok <= 1'b0;
        end else if (w_push) begin
            r_last    <= r_s0_beat;
            r_last_ok <= 1'b1;
        end
    end

    xy_gfx_ring #(
        .W     (BW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_s0_beat),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_level (fifo_level),
        .o_evict (w_evict)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_beat  <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_beat  <= gfx_beat_t'(w_head);
        end else if (m_gfx_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_skip_cnt <= '0;
        end else begin
            if (w_evict && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            if ((w_skip_blank || w_dup) && r_skip_cnt != '1) r_skip_cnt <= r_skip_cnt + 1'b1;
        end
    end

    assign s_ready     = 1'b1;
    assign m_gfx_valid = r_out_valid;
    assign m_gfx_x     = r_out_beat.x;
    assign m_gfx_y     = r_out_beat.y;
    assign m_gfx_pixel = r_out_beat.pixel;
    assign drop_cnt    = r_drop_cnt;
    assign skip_cnt    = r_skip_cnt;

endmodule

// File: tb/tb_xy_gfx_fifo.sv
// Self-checking bench for xy_gfx_fifo: filter vector table, latency, overflow, reset
// and colour-expansion sequences, with a scoreboard on the output handshake.
module tb_xy_gfx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0, s_ready;
    logic [9:0]  s_x = '0, s_y = '0;
    logic [0:0]  s_red = '0, s_grn = '0, s_blu = '0;
    logic        cfg_dedup = 1'b0, cfg_skip_blank = 1'b0;
    logic        m_gfx_valid, m_gfx_ready = 1'b1;
    logic [11:0] m_gfx_x, m_gfx_y, m_gfx_pixel;
    logic [15:0] drop_cnt, skip_cnt;
    logic [3:0]  fifo_level;

    xy_gfx_fifo #(.IN_WIDTH(10), .H_WIDTH(12), .V_WIDTH(12), .PIXEL_WIDTH(12),
                  .COLOR_IN_WIDTH(1), .DEPTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .s_red(s_red), .s_grn(s_grn), .s_blu(s_blu),
        .cfg_dedup(cfg_dedup), .cfg_skip_blank(cfg_skip_blank),
        .m_gfx_valid(m_gfx_valid), .m_gfx_x(m_gfx_x), .m_gfx_y(m_gfx_y),
        .m_gfx_pixel(m_gfx_pixel), .m_gfx_ready(m_gfx_ready),
        .drop_cnt(drop_cnt), .skip_cnt(skip_cnt), .fifo_level(fifo_level));

    // Colour-expansion instances with wider input channels.
    logic        c_valid = 1'b0;
    logic [1:0]  c2_r = '0, c2_g = '0, c2_b = '0;
    logic [5:0]  c6_r = '0, c6_g = '0, c6_b = '0;
    logic        c2_sr, c2_v, c6_sr, c6_v;
    logic [11:0] c2_x, c2_y, c2_p, c6_x, c6_y, c6_p;
    logic [15:0] c2_dc, c2_sc, c6_dc, c6_sc;
    logic [3:0]  c2_lv, c6_lv;

    xy_gfx_fifo #(.COLOR_IN_WIDTH(2)) u_c2 (
        .clk(clk), .rst(rst), .s_valid(c_valid), .s_ready(c2_sr),
        .s_x(10'd0), .s_y(10'd0), .s_red(c2_r), .s_grn(c2_g), .s_blu(c2_b),
        .cfg_dedup(1'b0), .cfg_skip_blank(1'b0),
        .m_gfx_valid(c2_v), .m_gfx_x(c2_x), .m_gfx_y(c2_y), .m_gfx_pixel(c2_p),
        .m_gfx_ready(1'b1), .drop_cnt(c2_dc), .skip_cnt(c2_sc), .fifo_level(c2_lv));

    xy_gfx_fifo #(.COLOR_IN_WIDTH(6)) u_c6 (
        .clk(clk), .rst(rst), .s_valid(c_valid), .s_ready(c6_sr),
        .s_x(10'd0), .s_y(10'd0), .s_red(c6_r), .s_grn(c6_g), .s_blu(c6_b),
        .cfg_dedup(1'b0), .cfg_skip_blank(1'b0),
        .m_gfx_valid(c6_v), .m_gfx_x(c6_x), .m_gfx_y(c6_y), .m_gfx_pixel(c6_p),
        .m_gfx_ready(1'b1), .drop_cnt(c6_dc), .skip_cnt(c6_sc), .fifo_level(c6_lv));

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] pix;
    } beat_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        r, g, b;
        logic        dedup, skipb;
        logic        emit;
        logic        last;
        logic [15:0] exp_skip;
        logic [11:0] exp_pix;
    } vec_t;

    beat_t sbq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    beat_t mon_e;
    always @(negedge clk) begin
        if (!rst && m_gfx_valid && m_gfx_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual x=%0h y=%0h pixel=%0h expected none",
                         m_gfx_x, m_gfx_y, m_gfx_pixel);
            end else begin
                mon_e = sbq.pop_front();
                chk("beat_x", 32'(m_gfx_x), 32'(mon_e.x));
                chk("beat_y", 32'(m_gfx_y), 32'(mon_e.y));
                chk("beat_pixel", 32'(m_gfx_pixel), 32'(mon_e.pix));
            end
        end
    end

    task automatic send(input logic [9:0] x, input logic [9:0] y,
                        input logic r, input logic g, input logic b);
        s_valid = 1'b1;
        s_x = x; s_y = y; s_red = r; s_grn = g; s_blu = b;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(sbq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    function automatic vec_t mk(input logic [9:0] x, input logic [9:0] y,
                                input logic [2:0] rgb, input logic dd, input logic sb,
                                input logic emit, input logic last,
                                input logic [15:0] es, input logic [11:0] ep);
        vec_t v;
        v.x = x; v.y = y; v.r = rgb[2]; v.g = rgb[1]; v.b = rgb[0];
        v.dedup = dd; v.skipb = sb; v.emit = emit; v.last = last;
        v.exp_skip = es; v.exp_pix = ep;
        return v;
    endfunction

    vec_t tab[14];

    initial begin
        // Group 1: dedup on, three repeats then a new x.
        tab[0]  = mk(10'd5, 10'd5, 3'b111, 1, 0, 1, 0, 16'd0, 12'hFFF);
        tab[1]  = mk(10'd5, 10'd5, 3'b111, 1, 0, 0, 0, 16'd0, 12'hFFF);
        tab[2]  = mk(10'd5, 10'd5, 3'b111, 1, 0, 0, 0, 16'd0, 12'hFFF);
        tab[3]  = mk(10'd6, 10'd5, 3'b111, 1, 0, 1, 1, 16'd2, 12'hFFF);
        // Group 2: dedup off, everything passes.
        tab[4]  = mk(10'd5, 10'd5, 3'b111, 0, 0, 1, 0, 16'd0, 12'hFFF);
        tab[5]  = mk(10'd5, 10'd5, 3'b111, 0, 0, 1, 0, 16'd0, 12'hFFF);
        tab[6]  = mk(10'd5, 10'd5, 3'b111, 0, 0, 1, 0, 16'd0, 12'hFFF);
        tab[7]  = mk(10'd6, 10'd5, 3'b111, 0, 0, 1, 1, 16'd0, 12'hFFF);
        // Group 3: blank skip clears last_ok, so A after blank is not deduped.
        tab[8]  = mk(10'd1, 10'd1, 3'b100, 1, 1, 1, 0, 16'd0, 12'hF00);
        tab[9]  = mk(10'd1, 10'd1, 3'b000, 1, 1, 0, 0, 16'd0, 12'h000);
        tab[10] = mk(10'd1, 10'd1, 3'b100, 1, 1, 1, 1, 16'd1, 12'hF00);
        // Group 4: blank pushed when skipping is off.
        tab[11] = mk(10'd1, 10'd1, 3'b100, 0, 0, 1, 0, 16'd0, 12'hF00);
        tab[12] = mk(10'd1, 10'd1, 3'b000, 0, 0, 1, 0, 16'd0, 12'h000);
        tab[13] = mk(10'd1, 10'd1, 3'b100, 0, 0, 1, 1, 16'd0, 12'hF00);

        // Reset state
        #1;
        chk("rst_valid", 32'(m_gfx_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        chk("rst_xyp", 32'({m_gfx_x, m_gfx_y, m_gfx_pixel} != '0), 32'd0);
        chk("s_ready", 32'(s_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency: accepted at edge k, valid after edge k+2
        sbq.push_back('{12'h155, 12'h2AA, 12'hF00});
        send(10'h155, 10'h2AA, 1'b1, 1'b0, 1'b0);
        chk("lat_k_valid", 32'(m_gfx_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_k1_valid", 32'(m_gfx_valid), 32'd0);
        chk("lat_k1_level", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        chk("lat_k2_valid", 32'(m_gfx_valid), 32'd1);
        chk("lat_k2_level", 32'(fifo_level), 32'd0);
        wait_drain();

        // Filter vector table
        for (int i = 0; i < 14; i++) begin
            cfg_dedup      = tab[i].dedup;
            cfg_skip_blank = tab[i].skipb;
            if (tab[i].emit)
                sbq.push_back('{12'(tab[i].x), 12'(tab[i].y), tab[i].exp_pix});
            send(tab[i].x, tab[i].y, tab[i].r, tab[i].g, tab[i].b);
            if (tab[i].last) begin
                repeat (3) @(posedge clk);
                #1;
                wait_drain();
                chk("grp_skip_cnt", 32'(skip_cnt), 32'(tab[i].exp_skip));
                chk("grp_drop_cnt", 32'(drop_cnt), 32'd0);
                do_reset();
            end
        end
        cfg_dedup = 1'b0;
        cfg_skip_blank = 1'b0;

        // Overflow: output holds x=0, ring keeps 2..9, one eviction
        m_gfx_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(10'(i), 10'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_valid", 32'(m_gfx_valid), 32'd1);
        chk("ovf_hold_x", 32'(m_gfx_x), 32'd0);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_drop", 32'(drop_cnt), 32'd1);
        sbq.push_back('{12'd0, 12'd0, 12'hF00});
        for (int i = 2; i < 10; i++) sbq.push_back('{12'(i), 12'd0, 12'hF00});
        m_gfx_ready = 1'b1;
        wait_drain();
        chk("ovf_idle_valid", 32'(m_gfx_valid), 32'd0);
        do_reset();

        // Mid-operation reset flushes buffer and output
        m_gfx_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(10'(16 + i), 10'd3, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_level", 32'(fifo_level), 32'd5);
        chk("pre_rst_valid", 32'(m_gfx_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(m_gfx_valid), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_cnts", 32'({drop_cnt, skip_cnt}), 32'd0);
        chk("mid_rst_pixel", 32'(m_gfx_pixel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        m_gfx_ready = 1'b1;
        cfg_dedup = 1'b1;
        sbq.push_back('{12'd21, 12'd3, 12'h0F0});
        send(10'd21, 10'd3, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        wait_drain();
        chk("post_rst_skip", 32'(skip_cnt), 32'd0);
        cfg_dedup = 1'b0;

        // Colour expansion for 2- and 6-bit channels
        c_valid = 1'b1;
        c2_r = 2'b10; c2_g = 2'b01; c2_b = 2'b11;
        c6_r = 6'b110011; c6_g = 6'b011111; c6_b = 6'b000000;
        @(posedge clk); #1;
        c_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("c2_valid", 32'(c2_v), 32'd1);
        chk("c2_pixel", 32'(c2_p), 32'hA5F);
        chk("c6_valid", 32'(c6_v), 32'd1);
        chk("c6_pixel", 32'(c6_p), 32'hC70);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
